// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch queue: entry payload, FSM states, break decode.
package dispatch_pkg;

  localparam int unsigned DISPATCH_DEPTH = 4;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned CYCLE_W        = 64;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] FUNCT_BREAK = 6'h0D;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
  } queue_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } dispatch_state_e;

  function automatic logic is_break(input logic [XLEN-1:0] word);
    return (word[31:26] == OP_RTYPE) && (word[5:0] == FUNCT_BREAK);
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular buffer of queue entries with push/pop/clear; head reads as zero when empty.
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DISPATCH_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  queue_entry_t               wdata_i,
  output queue_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  queue_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/dispatch_queue.sv
// Instruction queue and dispatch gate: issue gating, break-halt FSM and free-running cycle counter.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DISPATCH_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_valid,
  input  logic [XLEN-1:0]     fetch_instr,
  input  logic [XLEN-1:0]     fetch_addr,
  output logic                fetch_ready,
  input  logic                rob_full,
  input  logic                rs_full,
  input  logic                flush,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     addr,
  output logic                issue,
  output logic                halted,
  output logic [CYCLE_W-1:0]  cycle_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  dispatch_state_e      state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [CW-1:0]        count;
  logic                 push;
  queue_entry_t         head;
  queue_entry_t         wdata;

  assign wdata = '{instr: fetch_instr, addr: fetch_addr};

  dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (issue),
    .clear_i (flush),
    .wdata_i (wdata),
    .head_o  (head),
    .count_o (count)
  );

  // Readiness ignores a same-cycle pop: a full queue never takes a push.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q + CYCLE_W'(1);
    fetch_ready = 1'b0;
    issue       = 1'b0;
    push        = 1'b0;
    if (state_q == RUN) begin
      fetch_ready = (count < CW'(DEPTH));
      issue       = (count != '0) && !rob_full && !rs_full && !flush;
      push        = fetch_valid && fetch_ready && !flush;
      if (issue && is_break(head.instr)) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  assign instr       = head.instr;
  assign addr        = head.addr;
  assign halted      = (state_q == HALT);
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios plus randomized traffic vs. a queue model.
module tb_dispatch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        rob_full;
  logic        rs_full;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        issue;
  logic        halted;
  logic [63:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t            mq[$];
  bit              m_halted;
  longint unsigned m_cyc;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .rob_full    (rob_full),
    .rs_full     (rs_full),
    .flush       (flush),
    .instr       (instr),
    .addr        (addr),
    .issue       (issue),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_brk(input logic [31:0] w);
    return (w[31:26] == 6'h00) && (w[5:0] == 6'h0D);
  endfunction

  // Drive one cycle of inputs, check outputs at negedge, then advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic robf, input logic rsf, input logic fl);
    bit exp_ready, exp_issue;
    fetch_valid = v;
    fetch_instr = ins;
    fetch_addr  = pc;
    rob_full    = robf;
    rs_full     = rsf;
    flush       = fl;
    @(negedge clk);
    exp_ready = (mq.size() < DEPTH) && !m_halted;
    exp_issue = (mq.size() > 0) && !robf && !rsf && !fl && !m_halted;
    chk("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
    chk("issue", 64'(issue), 64'(exp_issue));
    chk("instr", 64'(instr), (mq.size() > 0) ? 64'(mq[0].ins) : 64'h0);
    chk("addr", 64'(addr), (mq.size() > 0) ? 64'(mq[0].pc) : 64'h0);
    chk("halted", 64'(halted), 64'(m_halted));
    chk("cycle_count", cycle_count, 64'(m_cyc));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_issue) begin
        if (is_brk(mq[0].ins)) m_halted = 1'b1;
        void'(mq.pop_front());
      end
      if (v && exp_ready) mq.push_back('{ins: ins, pc: pc});
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0;
    fetch_instr = '0;
    fetch_addr  = '0;
    rob_full    = 1'b0;
    rs_full     = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mq.delete();
    m_halted = 1'b0;
    m_cyc    = 0;
  endtask

  initial begin
    do_reset();

    // Idle after reset: third edge shows cycle_count 3.
    idle(3);
    chk("idle_cycle3", cycle_count, 64'd3);
    chk("idle_issue", 64'(issue), 64'd0);
    chk("idle_ready", 64'(fetch_ready), 64'd1);

    // Streaming addiu pushes, no stalls.
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'h24010005, 32'h00400000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    idle(2);

    // Back-pressure from ROB: fill, then drain while the 5th waits.
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h24020000 + 32'(i), 32'h00401000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h24020004, 32'h00401010, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Flush with three entries queued and a concurrent push.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h24030000 + 32'(i), 32'h00402000 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h24039999, 32'h00402100, 1'b0, 1'b0, 1'b1);
    chk("post_flush_instr", 64'(instr), 64'h0);
    idle(2);

    // break followed by addu: break issues, then dispatch halts for good.
    step(1'b1, 32'h0000000D, 32'h00403000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00221821, 32'h00403004, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_ready", 64'(fetch_ready), 64'd0);
    step(1'b1, 32'h24010001, 32'h00403008, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with two entries queued.
    do_reset();
    idle(2);
    step(1'b1, 32'h24040001, 32'h00404000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h24040002, 32'h00404004, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_instr", 64'(instr), 64'h24040001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_instr", 64'(instr), 64'h0);
    chk("async_addr", 64'(addr), 64'h0);
    chk("async_issue", 64'(issue), 64'd0);
    chk("async_ready", 64'(fetch_ready), 64'd1);
    chk("async_cycle", cycle_count, 64'd0);
    chk("async_halted", 64'(halted), 64'd0);
    do_reset();

    // Randomized traffic against the model, with periodic resets to escape HALT.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        logic [31:0] ri;
        ri = ($urandom_range(0, 39) == 0) ? 32'h0000000D : 32'($urandom);
        step($urandom_range(0, 9) < 7, ri, 32'($urandom) & 32'hFFFF_FFFC,
             $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 19) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
